// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
// State names, opcode constants and the mux-select encodings seen by the datapath.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_AUIPC,
    S_FAULT
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // States that hold a request on the shared memory port until mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles on the memory port and flags the last allowed one.
// TIMEOUT of 0 turns the check off entirely.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear) begin
      wait_cnt_d = '0;
    end else if (waiting) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Expiry moves the FSM out of the memory state, which clears the count before it can wrap.
  assign expired = (TIMEOUT != 0) && waiting && (wait_cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch, decode, execute, memory and writeback.
// Selects are decoded from state; the fetch/branch write strobes also look at mem_ready/zero.
module multicycle_controller
  import riscv_mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       f7b5_valid,
  output logic       instr_retired,
  output logic       fault
);

  state_t state_q, state_d;
  logic   waiting, expired;

  assign waiting = is_mem_state(state_q) && !mem_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_mem_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .clear   (mem_ready || (state_d != state_q)),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_R:               state_d = S_EXEC_R;
          OPC_I:               state_d = S_EXEC_I;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_AUIPC;
          default:             state_d = S_FAULT;
        endcase
      end
      S_MEMADR:  state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (expired) state_d = S_FAULT;
      end
      S_MEMWRITE: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (expired) state_d = S_FAULT;
      end
      S_MEMWB, S_ALUWB, S_BRANCH:                 state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_LUI, S_AUIPC:  state_d = S_ALUWB;
      S_FAULT:                                    state_d = S_FAULT;
      default:                                    state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no state path can infer a latch.
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    alu_op        = ALUOP_ADD;
    f7b5_valid    = 1'b0;
    instr_retired = (state_q != S_FETCH) && (state_d == S_FETCH);
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        f7b5_valid = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        f7b5_valid = (funct3 == 3'b101);
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero ^ funct3[0];
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_PASS;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      default: ;
    endcase
    // An instruction interrupted by reset must not touch architectural state.
    if (reset) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
    end
  end

  assign fault = (state_q == S_FAULT);

endmodule
